iopad_dir_ctrl: RTL and testbench

//  Direction/turnaround sequencer for one bidirectional PDD IO pad cell (I/OEN/REN/PAD/C).

---
 rtl/iopad_dir_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_iopad_dir_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iopad_dir_ctrl.sv
// iopad_dir_ctrl: direction/turnaround sequencer for one bidirectional pad.
// Grants one drive requester ownership of the pad, with guard cycles on both sides.
// A watchdog limits how long the pad is driven.
// The pad input is synchronised and deglitched, but only while the pad is receiving.
//
// Handshake: drv_req is a level request and drv_ack is the grant.
// drv_ack is high exactly while the pad is actively driven.
// A request that is withdrawn before the grant is dropped without ever driving the pad.
// After a watchdog timeout the request must fall and rise again before a new grant.
module iopad_dir_ctrl #(
  parameter int TURN_CYC = 2,
  parameter int FILT_LEN = 3,
  parameter int DRV_MAX  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic drv_req,
  input  logic drv_data,
  input  logic pull_en,
  input  logic drv_to_clr,
  output logic drv_ack,
  output logic drv_to,
  output logic busy,
  output logic rx_level,
  output logic rx_rise,
  output logic rx_fall,
  output logic pad_i,
  output logic pad_oen,
  output logic pad_ren,
  input  logic pad_c
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] DRV_LAST  = CNT_W'(DRV_MAX - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_LEN - 1);
  localparam logic             DRV_LIMIT = (DRV_MAX != 0);

  // Sequencer state and counters.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             lockout_q, lockout_d;
  logic             drv_to_q, drv_to_d;
  logic             timeout_hit;

  // Registered pad controls and status.
  logic pad_i_q, pad_i_d;
  logic pad_oen_q, pad_oen_d;
  logic pad_ren_q, pad_ren_d;
  logic drv_ack_q, drv_ack_d;
  logic busy_q, busy_d;

  // Input synchroniser and deglitch filter.
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             rx_level_q, rx_level_d;
  logic             rx_rise_q, rx_rise_d;
  logic             rx_fall_q, rx_fall_d;

  // Next-state logic: turnaround timing, drive watchdog, request lockout.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    dcnt_d      = dcnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drv_req && !lockout_q) begin
          state_d = ST_TURN_OUT;
          tcnt_d  = TURN_LAST;
        end
      end
      ST_TURN_OUT: begin
        if (!drv_req) begin
          // Request withdrawn before the grant: back off without driving.
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == '0) begin
          state_d = ST_DRIVE;
          dcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q - CNT_ONE;
        end
      end
      ST_DRIVE: begin
        if (!drv_req) begin
          state_d = ST_TURN_IN;
          tcnt_d  = TURN_LAST;
        end else if (DRV_LIMIT && (dcnt_q == DRV_LAST)) begin
          // Last permitted drive cycle and the requester still holds on.
          state_d     = ST_TURN_IN;
          tcnt_d      = TURN_LAST;
          timeout_hit = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      ST_TURN_IN: begin
        if (tcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Lockout and the sticky timeout flag; a new timeout beats a clear pulse.
  always_comb begin
    lockout_d = drv_req ? (lockout_q | timeout_hit) : 1'b0;
    drv_to_d  = timeout_hit | (drv_to_q & ~drv_to_clr);
  end

  // Pad controls decoded from next state so they line up with the registered state.
  always_comb begin
    pad_oen_d = (state_d != ST_DRIVE);
    pad_ren_d = (state_d == ST_IDLE) ? ~pull_en : 1'b1;
    pad_i_d   = ((state_d == ST_TURN_OUT) || (state_d == ST_DRIVE)) ? drv_data : 1'b0;
    drv_ack_d = (state_d == ST_DRIVE);
    busy_d    = (state_d != ST_IDLE);
  end

  // Synchroniser plus a run-length filter; frozen whenever the pad is not receiving.
  always_comb begin
    sync1_d    = pad_c;
    sync2_d    = sync1_q;
    fcnt_d     = fcnt_q;
    rx_level_d = rx_level_q;
    rx_rise_d  = 1'b0;
    rx_fall_d  = 1'b0;
    if (state_q != ST_IDLE) begin
      fcnt_d = '0;
    end else if (sync2_q != rx_level_q) begin
      if (fcnt_q == FILT_LAST) begin
        rx_level_d = ~rx_level_q;
        rx_rise_d  = ~rx_level_q;
        rx_fall_d  = rx_level_q;
        fcnt_d     = '0;
      end else begin
        fcnt_d = fcnt_q + CNT_ONE;
      end
    end else begin
      fcnt_d = '0;
    end
  end

  // All state; the async reset releases the pad immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      dcnt_q     <= '0;
      lockout_q  <= 1'b0;
      drv_to_q   <= 1'b0;
      pad_i_q    <= 1'b0;
      pad_oen_q  <= 1'b1;
      pad_ren_q  <= 1'b1;
      drv_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      fcnt_q     <= '0;
      rx_level_q <= 1'b0;
      rx_rise_q  <= 1'b0;
      rx_fall_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      dcnt_q     <= dcnt_d;
      lockout_q  <= lockout_d;
      drv_to_q   <= drv_to_d;
      pad_i_q    <= pad_i_d;
      pad_oen_q  <= pad_oen_d;
      pad_ren_q  <= pad_ren_d;
      drv_ack_q  <= drv_ack_d;
      busy_q     <= busy_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      fcnt_q     <= fcnt_d;
      rx_level_q <= rx_level_d;
      rx_rise_q  <= rx_rise_d;
      rx_fall_q  <= rx_fall_d;
    end
  end

  assign drv_ack  = drv_ack_q;
  assign drv_to   = drv_to_q;
  assign busy     = busy_q;
  assign rx_level = rx_level_q;
  assign rx_rise  = rx_rise_q;
  assign rx_fall  = rx_fall_q;
  assign pad_i    = pad_i_q;
  assign pad_oen  = pad_oen_q;
  assign pad_ren  = pad_ren_q;

endmodule

// File: tb/tb_iopad_dir_ctrl.sv
// tb_iopad_dir_ctrl: directed scenarios for the pad direction sequencer.
// Each step drives one cycle of inputs and queues the expected output vector for the next cycle.
// Vector bit order: {busy, drv_ack, drv_to, pad_oen, pad_ren, pad_i, rx_level, rx_rise, rx_fall}.
module tb_iopad_dir_ctrl;

  localparam int S_ID = 0;
  localparam int S_TO = 1;
  localparam int S_DR = 2;
  localparam int S_TI = 3;

  // Clock and reset.
  logic clk;
  logic rst;
  logic drv_req, drv_data, pull_en, drv_to_clr, pad_c;
  logic drv_ack, drv_to, busy, rx_level, rx_rise, rx_fall, pad_i, pad_oen, pad_ren;

  logic [8:0]  obs;
  logic [17:0] exp_q[$];
  logic        pull_v;
  int          n_vec;
  int          n_err;

  assign obs = {busy, drv_ack, drv_to, pad_oen, pad_ren, pad_i, rx_level, rx_rise, rx_fall};

  iopad_dir_ctrl #(
    .TURN_CYC(2),
    .FILT_LEN(3),
    .DRV_MAX (8),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .drv_req   (drv_req),
    .drv_data  (drv_data),
    .pull_en   (pull_en),
    .drv_to_clr(drv_to_clr),
    .drv_ack   (drv_ack),
    .drv_to    (drv_to),
    .busy      (busy),
    .rx_level  (rx_level),
    .rx_rise   (rx_rise),
    .rx_fall   (rx_fall),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .pad_ren   (pad_ren),
    .pad_c     (pad_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  // Single comparison point.
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected {mask, value} for a cycle spent in the given state.
  function automatic logic [17:0] exp_vec(input int st, input logic pi, input logic to,
                                          input logic lvl, input logic rise, input logic fall,
                                          input logic pull);
    logic [8:0] v;
    logic [8:0] m;
    m = 9'h1FF;
    case (st)
      S_ID:    begin v = {1'b0, 1'b0, to, 1'b1, ~pull, 1'b0, lvl, rise, fall}; m[3] = 1'b0; end
      S_TO:    v = {1'b1, 1'b0, to, 1'b1, 1'b1, pi, lvl, rise, fall};
      S_DR:    v = {1'b1, 1'b1, to, 1'b0, 1'b1, pi, lvl, rise, fall};
      default: begin v = {1'b1, 1'b0, to, 1'b1, 1'b1, 1'b0, lvl, rise, fall}; m[3] = 1'b0; end
    endcase
    return {m, v};
  endfunction

  // Driver: apply one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string tag, input int k, input logic req, input logic data,
                      input logic pc, input logic clr, input int st, input logic pi,
                      input logic to, input logic lvl, input logic rise, input logic fall);
    logic [17:0] e;
    drv_req    = req;
    drv_data   = data;
    pad_c      = pc;
    drv_to_clr = clr;
    pull_en    = pull_v;
    exp_q.push_back(exp_vec(st, pi, to, lvl, rise, fall, pull_v));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s.%0d", tag, k), obs & e[17:9], e[8:0] & e[17:9]);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    pull_v     = 1'b0;
    rst        = 1'b1;
    drv_req    = 1'b0;
    drv_data   = 1'b0;
    pull_en    = 1'b0;
    drv_to_clr = 1'b0;
    pad_c      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs, 9'b000110000);
    rst = 1'b0;

    // Basic grant: two turn-out cycles, drive with 1-cycle data latency, two turn-in cycles.
    step("grant", 0, 1, 1, 0, 0, S_TO, 1, 0, 0, 0, 0);
    step("grant", 1, 1, 1, 0, 0, S_TO, 1, 0, 0, 0, 0);
    step("grant", 2, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    step("grant", 3, 1, 0, 0, 0, S_DR, 0, 0, 0, 0, 0);
    step("grant", 4, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    step("grant", 5, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    step("grant", 6, 0, 1, 0, 0, S_TI, 0, 0, 0, 0, 0);
    step("grant", 7, 0, 1, 0, 0, S_TI, 0, 0, 0, 0, 0);
    step("grant", 8, 0, 1, 0, 0, S_ID, 0, 0, 0, 0, 0);
    step("grant", 9, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);

    // One-cycle request: turn-out then straight back to idle, pad never driven.
    step("pulse", 0, 1, 0, 0, 0, S_TO, 0, 0, 0, 0, 0);
    step("pulse", 1, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);
    step("pulse", 2, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);

    // Watchdog: held request gets exactly 8 drive cycles, timeout wins over a clear,
    // and the held request is locked out.
    for (int i = 0; i < 20; i++) begin
      int st;
      st = (i < 2) ? S_TO : (i < 10) ? S_DR : (i < 12) ? S_TI : S_ID;
      step("wdog", i, 1, 1, 0, (i == 10), st, 1, (i >= 10), 0, 0, 0);
    end
    step("wdog", 20, 0, 1, 0, 0, S_ID, 0, 1, 0, 0, 0);
    step("wdog", 21, 1, 1, 0, 0, S_TO, 1, 1, 0, 0, 0);
    step("wdog", 22, 0, 1, 0, 0, S_ID, 0, 1, 0, 0, 0);
    step("wdog", 23, 0, 0, 0, 1, S_ID, 0, 0, 0, 0, 0);
    step("wdog", 24, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);

    // Pad input held high while driving must not reach rx_level.
    step("frz", 0, 1, 1, 0, 0, S_TO, 1, 0, 0, 0, 0);
    step("frz", 1, 1, 1, 0, 0, S_TO, 1, 0, 0, 0, 0);
    step("frz", 2, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    for (int i = 3; i < 8; i++) begin
      step("frz", i, 1, 1, 1, 0, S_DR, 1, 0, 0, 0, 0);
    end
    step("frz", 8, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    step("frz", 9, 0, 1, 0, 0, S_TI, 0, 0, 0, 0, 0);
    step("frz", 10, 0, 1, 0, 0, S_TI, 0, 0, 0, 0, 0);
    for (int i = 11; i < 15; i++) begin
      step("frz", i, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);
    end

    // Receive filter in idle with the pull enabled: short glitch ignored, then rise and fall.
    pull_v = 1'b1;
    step("rx", 0, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);
    step("rx", 1, 0, 0, 1, 0, S_ID, 0, 0, 0, 0, 0);
    step("rx", 2, 0, 0, 1, 0, S_ID, 0, 0, 0, 0, 0);
    for (int i = 3; i < 9; i++) begin
      step("rx", i, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);
    end
    for (int j = 0; j < 8; j++) begin
      step("rise", j, 0, 0, 1, 0, S_ID, 0, 0, (j >= 4), (j == 4), 0);
    end
    for (int j = 0; j < 8; j++) begin
      step("fall", j, 0, 0, 0, 0, S_ID, 0, 0, (j < 4), 0, (j == 4));
    end
    pull_v = 1'b0;
    step("rx", 9, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);

    // Reset in the middle of a drive releases the pad without a clock edge.
    step("arst", 0, 1, 1, 0, 0, S_TO, 1, 0, 0, 0, 0);
    step("arst", 1, 1, 1, 0, 0, S_TO, 1, 0, 0, 0, 0);
    step("arst", 2, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    step("arst", 3, 1, 1, 0, 0, S_DR, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.async", obs, 9'b000110000);
    drv_req = 1'b0;
    #1;
    rst = 1'b0;
    step("arst", 4, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);
    step("arst", 5, 0, 0, 0, 0, S_ID, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
